// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath: decodes op/func, drives every
// write enable and mux select one state per cycle, and counts retired instructions.
module multicycle_control #(
    parameter logic [5:0]  HALT_OP = 6'b111111,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemRd,
    output logic             MemWr,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUCtl,
    output logic             ExtOp,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       PCSrc,
    output logic [2:0]       state,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic is_rtype, is_jr, is_jalr, is_j, is_jal, is_beq, is_bne;
    logic is_alui, is_logic_imm, is_load, is_store, is_halt, is_legal;

    assign is_rtype     = (op == OP_RTYPE);
    assign is_jr        = is_rtype && (func == FN_JR);
    assign is_jalr      = is_rtype && (func == FN_JALR);
    assign is_j         = (op == OP_J);
    assign is_jal       = (op == OP_JAL);
    assign is_beq       = (op == OP_BEQ);
    assign is_bne       = (op == OP_BNE);
    assign is_alui      = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    assign is_logic_imm = op inside {OP_ANDI, OP_ORI, OP_XORI};
    assign is_load      = op inside {OP_LW, OP_LB, OP_LBU};
    assign is_store     = op inside {OP_SW, OP_SB};
    assign is_halt      = (op == HALT_OP);
    assign is_legal     = is_rtype || is_alui || is_load || is_store ||
                          is_beq || is_bne || is_j || is_jal;

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no path infers a latch.
        state_d   = state_q;
        illegal_d = illegal_q;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        RegWr     = 1'b0;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUCtl    = 2'b00;
        ExtOp     = 1'b0;
        RegDst    = 2'b00;
        MemtoReg  = 2'b00;
        PCSrc     = 2'b00;

        unique case (state_q)
            S_IF: begin
                IRWr    = 1'b1;
                PCWr    = 1'b1;
                ALUSrcB = 2'b01;
                state_d = S_ID;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (is_j || is_jal) begin
                    PCWr    = 1'b1;
                    PCSrc   = 2'b10;
                    state_d = S_IF;
                    if (is_jal) begin
                        RegWr    = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end else if (is_jr || is_jalr) begin
                    PCWr    = 1'b1;
                    PCSrc   = 2'b11;
                    state_d = S_IF;
                    if (is_jalr) begin
                        RegWr    = 1'b1;
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                    end
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                state_d = S_IF;
                if (is_rtype) begin
                    ALUCtl  = 2'b10;
                    state_d = S_WB;
                end else if (is_alui) begin
                    ALUSrcB = 2'b10;
                    ALUCtl  = 2'b11;
                    ExtOp   = !is_logic_imm;
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                    state_d = S_MEM;
                end else if (is_beq || is_bne) begin
                    ALUCtl = 2'b01;
                    PCSrc  = 2'b01;
                    PCWr   = is_beq ? Zero : !Zero;
                end
            end
            S_MEM: begin
                MemRd = is_load;
                MemWr = is_store;
                if (MemReady) state_d = is_load ? S_WB : S_IF;
            end
            S_WB: begin
                RegWr    = 1'b1;
                RegDst   = is_rtype ? 2'b01 : 2'b00;
                MemtoReg = is_load  ? 2'b01 : 2'b00;
                state_d  = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase

        // Reset aborts whatever is in flight: no datapath write may escape this cycle.
        if (Reset) begin
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RegWr   = 1'b0;
            MemRd   = 1'b0;
            MemWr   = 1'b0;
            state_d = S_IF;
        end
    end

    always_comb begin
        count_d = count_q;
        if (!Reset && state_d == S_IF && state_q inside {S_ID, S_EXE, S_MEM, S_WB})
            count_d = count_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign state      = state_q;
    assign Illegal    = illegal_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle's expected outputs are queued
// when stimulus is driven and compared at the following falling edge.
module tb_multicycle_control;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [5:0] R = 6'b000000, ADDU = 6'b100001, JR = 6'b001000;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] JAL = 6'b000011, ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] BADOP = 6'b010000, HALT = 6'b111111;

    logic        CLK, Reset, Zero, MemReady;
    logic [5:0]  op, func;
    logic        PCWr, IRWr, RegWr, MemRd, MemWr, ALUSrcA, ExtOp, Illegal;
    logic [1:0]  ALUSrcB, ALUCtl, RegDst, MemtoReg, PCSrc;
    logic [2:0]  state;
    logic [31:0] InstrCount;

    typedef struct packed {
        logic [2:0]  st;
        logic [4:0]  en;   // PCWr, IRWr, RegWr, MemRd, MemWr
        logic        srca;
        logic [1:0]  srcb;
        logic [1:0]  ctl;
        logic        ext;
        logic [1:0]  dst;
        logic [1:0]  m2r;
        logic [1:0]  pcs;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   step    = 0;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .op(op), .func(func), .Zero(Zero), .MemReady(MemReady),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemRd(MemRd), .MemWr(MemWr),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl), .ExtOp(ExtOp),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .state(state),
        .Illegal(Illegal), .InstrCount(InstrCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL step%0d %s: observed %0h expected %0h", step, tag, obs, exp);
    endtask

    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("state",    32'(state), 32'(e.st));
            chk("enables",  32'({PCWr, IRWr, RegWr, MemRd, MemWr}), 32'(e.en));
            chk("ALUSrcA",  32'(ALUSrcA), 32'(e.srca));
            chk("ALUSrcB",  32'(ALUSrcB), 32'(e.srcb));
            chk("ALUCtl",   32'(ALUCtl), 32'(e.ctl));
            chk("ExtOp",    32'(ExtOp), 32'(e.ext));
            chk("RegDst",   32'(RegDst), 32'(e.dst));
            chk("MemtoReg", 32'(MemtoReg), 32'(e.m2r));
            chk("PCSrc",    32'(PCSrc), 32'(e.pcs));
            chk("Illegal",  32'(Illegal), 32'(e.ill));
            chk("InstrCount", InstrCount, e.cnt);
        end
    end

    function automatic exp_t mk(input logic [2:0] st, input logic [4:0] en, input logic srca,
                                input logic [1:0] srcb, input logic [1:0] ctl, input logic ext,
                                input logic [1:0] dst, input logic [1:0] m2r, input logic [1:0] pcs,
                                input logic ill, input logic [31:0] cnt);
        exp_t e;
        e = '{st: st, en: en, srca: srca, srcb: srcb, ctl: ctl, ext: ext,
              dst: dst, m2r: m2r, pcs: pcs, ill: ill, cnt: cnt};
        return e;
    endfunction

    function automatic exp_t e_if(input logic [31:0] cnt);
        return mk(S_IF, 5'b11000, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, cnt);
    endfunction

    function automatic exp_t e_id(input logic [31:0] cnt);
        return mk(S_ID, 5'b00000, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, cnt);
    endfunction

    function automatic exp_t e_halt(input logic ill, input logic [31:0] cnt);
        return mk(S_HALT, 5'b00000, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, ill, cnt);
    endfunction

    // Drive one cycle of inputs, queue the outputs expected during that cycle.
    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic mr, input logic rst, input exp_t e);
        op = o; func = f; Zero = z; MemReady = mr; Reset = rst;
        step++;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1; op = '0; func = '0; Zero = 1'b0; MemReady = 1'b0;
        @(posedge CLK);
        #1;
        cyc(R, ADDU, 0, 0, 1, mk(S_IF, 5'b00000, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));

        // addu: IF, ID, EXE, WB
        cyc(R, ADDU, 0, 0, 0, e_if(0));
        cyc(R, ADDU, 0, 0, 0, e_id(0));
        cyc(R, ADDU, 0, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b00, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc(R, ADDU, 0, 0, 0, mk(S_WB, 5'b00100, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0));

        // lw with two wait states
        cyc(LW, 0, 0, 0, 0, e_if(1));
        cyc(LW, 0, 0, 0, 0, e_id(1));
        cyc(LW, 0, 0, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 1));
        cyc(LW, 0, 0, 0, 0, mk(S_MEM, 5'b00010, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        cyc(LW, 0, 0, 0, 0, mk(S_MEM, 5'b00010, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        cyc(LW, 0, 0, 1, 0, mk(S_MEM, 5'b00010, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        cyc(LW, 0, 0, 0, 0, mk(S_WB, 5'b00100, 0, 2'b00, 2'b00, 0, 2'b00, 2'b01, 2'b00, 0, 1));

        // beq taken / not taken, bne taken / not taken
        cyc(BEQ, 0, 1, 0, 0, e_if(2));
        cyc(BEQ, 0, 1, 0, 0, e_id(2));
        cyc(BEQ, 0, 1, 0, 0, mk(S_EXE, 5'b10000, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b01, 0, 2));
        cyc(BEQ, 0, 0, 0, 0, e_if(3));
        cyc(BEQ, 0, 0, 0, 0, e_id(3));
        cyc(BEQ, 0, 0, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b01, 0, 3));
        cyc(BNE, 0, 1, 0, 0, e_if(4));
        cyc(BNE, 0, 1, 0, 0, e_id(4));
        cyc(BNE, 0, 1, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b01, 0, 4));
        cyc(BNE, 0, 0, 0, 0, e_if(5));
        cyc(BNE, 0, 0, 0, 0, e_id(5));
        cyc(BNE, 0, 0, 0, 0, mk(S_EXE, 5'b10000, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b01, 0, 5));

        // jal and jr complete in ID
        cyc(JAL, 0, 0, 0, 0, e_if(6));
        cyc(JAL, 0, 0, 0, 0, mk(S_ID, 5'b10100, 0, 2'b11, 2'b00, 0, 2'b10, 2'b10, 2'b10, 0, 6));
        cyc(R, JR, 0, 0, 0, e_if(7));
        cyc(R, JR, 0, 0, 0, mk(S_ID, 5'b10000, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 7));

        // addi sign-extends, ori zero-extends
        cyc(ADDI, 0, 0, 0, 0, e_if(8));
        cyc(ADDI, 0, 0, 0, 0, e_id(8));
        cyc(ADDI, 0, 0, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b10, 2'b11, 1, 2'b00, 2'b00, 2'b00, 0, 8));
        cyc(ADDI, 0, 0, 0, 0, mk(S_WB, 5'b00100, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 8));
        cyc(ORI, 0, 0, 0, 0, e_if(9));
        cyc(ORI, 0, 0, 0, 0, e_id(9));
        cyc(ORI, 0, 0, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b10, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 9));
        cyc(ORI, 0, 0, 0, 0, mk(S_WB, 5'b00100, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 9));

        // illegal opcode parks in HALT with Illegal set, then reset recovers
        cyc(BADOP, 0, 0, 0, 0, e_if(10));
        cyc(BADOP, 0, 0, 0, 0, e_id(10));
        for (int i = 0; i < 10; i++) cyc(BADOP, 0, 1, 1, 0, e_halt(1, 10));
        cyc(BADOP, 0, 0, 0, 1, e_halt(1, 10));

        // sw aborted by reset while waiting in MEM
        cyc(SW, 0, 0, 0, 0, e_if(0));
        cyc(SW, 0, 0, 0, 0, e_id(0));
        cyc(SW, 0, 0, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc(SW, 0, 0, 0, 0, mk(S_MEM, 5'b00001, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc(SW, 0, 0, 0, 1, mk(S_MEM, 5'b00000, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));

        // sw with zero wait states retires straight from MEM
        cyc(SW, 0, 0, 0, 0, e_if(0));
        cyc(SW, 0, 0, 0, 0, e_id(0));
        cyc(SW, 0, 0, 0, 0, mk(S_EXE, 5'b00000, 1, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0));
        cyc(SW, 0, 0, 1, 0, mk(S_MEM, 5'b00001, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));

        // HALT opcode stops without flagging Illegal or retiring
        cyc(HALT, 0, 0, 0, 0, e_if(1));
        cyc(HALT, 0, 0, 0, 0, e_id(1));
        cyc(HALT, 0, 1, 1, 0, e_halt(0, 1));
        cyc(HALT, 0, 0, 0, 0, e_halt(0, 1));

        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
